chan_sel_mux: RTL and testbench



---
 rtl/chan_sel_pkg.sv | 20 ++
 rtl/chan_sel_mux_if.sv | 31 +++
 rtl/chan_sel_mux_rr_pick.sv | 35 +++
 rtl/chan_sel_mux.sv | 86 ++++++++
 tb/tb_chan_sel_mux.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/chan_sel_pkg.sv
// rtl/chan_sel_pkg.sv - shared encodings and index helpers for chan_sel_mux
// Purpose: mode encodings, channel-index width and a wrapping increment
//          for channel pointers.
// Ports:   none (package)
package chan_sel_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a channel index; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Next channel index with wrap at n, valid for any n (not only powers of 2).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/chan_sel_mux_if.sv
// rtl/chan_sel_mux_if.sv - channel input bus and output word bus
// Purpose: bundles the per-channel inputs and the registered output stream.
// Ports:   in_data/in_valid/in_ready (channels), out_data/out_ch/out_valid/out_ready (output)
//          master = source/sink side, slave = mux side.
interface chan_sel_mux_if
  import chan_sel_pkg::*;
#(
  parameter int N_CH = 32,
  parameter int DW   = 8
);
  localparam int SW = idx_width(N_CH);

  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]    in_valid;
  logic [N_CH-1:0]    in_ready;
  logic [DW-1:0]      out_data;
  logic [SW-1:0]      out_ch;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/chan_sel_mux_rr_pick.sv
// rtl/chan_sel_mux_rr_pick.sv - combinational rotating-priority picker
// Purpose: grants the first set req bit at or above ptr, wrapping N-1 -> 0.
// Ports:   req (request vector), ptr (search start, must be < N),
//          gnt (one-hot grant), idx (grant index), any (some request set)
module rr_pick #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // One extra bit so ptr + i never overflows before the wrap subtraction.
  logic [W:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr} + (W+1)'(i);
      if (k >= (W+1)'(N)) k = k - (W+1)'(N);
      if (!any && req[k[W-1:0]]) begin
        any            = 1'b1;
        gnt[k[W-1:0]]  = 1'b1;
        idx            = k[W-1:0];
      end
    end
  end

endmodule

// File: rtl/chan_sel_mux.sv
// rtl/chan_sel_mux.sv - N-channel selector with manual and round-robin modes
// Purpose: moves one word per cycle from a selected channel into a
//          registered output stage with valid/ready flow control.
// Ports:   clk, rst (sync, active-high), mode (0 manual, 1 scan),
//          sel (manual channel), sel_err (pulse on out-of-range sel),
//          bus (chan_sel_mux_if.slave: channel inputs and output word)
module chan_sel_mux
  import chan_sel_pkg::*;
#(
  parameter  int N_CH = 32,
  parameter  int DW   = 8,
  localparam int SW   = idx_width(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic          sel_err,
  chan_sel_mux_if.slave bus
);

  logic [SW-1:0]   ptr;
  logic [N_CH-1:0] pick_gnt;
  logic [SW-1:0]   pick_idx;
  logic            pick_any;
  logic            ld;
  logic            sel_ok;
  logic            xfer;
  logic [SW-1:0]   xfer_idx;
  logic [DW-1:0]   xfer_data;

  rr_pick #(.N(N_CH), .W(SW)) u_pick (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ld     = !bus.out_valid || bus.out_ready;
  assign sel_ok = (32'(sel) < 32'(N_CH));

  // in_ready depends on out_ready only through ld; reset blocks any transfer.
  always_comb begin
    bus.in_ready = '0;
    if (!rst) begin
      if (mode == MODE_MANUAL) begin
        if (sel_ok) bus.in_ready[sel] = ld;
      end else if (pick_any) begin
        bus.in_ready = pick_gnt & {N_CH{ld}};
      end
    end
  end

  assign xfer     = |(bus.in_valid & bus.in_ready);
  assign xfer_idx = (mode == MODE_SCAN) ? pick_idx : sel;

  always_comb begin
    xfer_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SW'(k) == xfer_idx) xfer_data = bus.in_data[k*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      sel_err       <= 1'b0;
      ptr           <= '0;
    end else begin
      sel_err <= (mode == MODE_MANUAL) && !sel_ok;
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= xfer_data;
        bus.out_ch    <= xfer_idx;
        if (mode == MODE_SCAN) ptr <= SW'(wrap_inc(int'(pick_idx), N_CH));
      end else if (bus.out_ready) begin
        // Drained with nothing to replace it; data/ch keep their last value.
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_sel_mux.sv
// tb/tb_chan_sel_mux.sv - scoreboard testbench for chan_sel_mux
module tb_chan_sel_mux;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic [4:0] sel;
  logic sel_err;

  logic mode24;
  logic [4:0] sel24;
  logic sel_err24;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  chan_sel_mux_if #(.N_CH(32), .DW(8)) bus ();
  chan_sel_mux_if #(.N_CH(24), .DW(8)) bus24 ();

  chan_sel_mux #(.N_CH(32), .DW(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .sel_err(sel_err), .bus(bus)
  );

  chan_sel_mux #(.N_CH(24), .DW(8)) dut24 (
    .clk(clk), .rst(rst), .mode(mode24), .sel(sel24), .sel_err(sel_err24), .bus(bus24)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dat(input int k);
    return 8'hA0 ^ 8'(k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got ch %0d with empty queue at %0t", bus.out_ch, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_ch", 64'(bus.out_ch), 64'(e));
        chk("sb_data", 64'(bus.out_data), 64'(dat(e)));
      end
    end
  end

  initial begin
    int e3[3];
    e3[0] = 30; e3[1] = 3; e3[2] = 30;
    for (int k = 0; k < 32; k++) bus.in_data[k*8 +: 8] = dat(k);
    for (int k = 0; k < 24; k++) bus24.in_data[k*8 +: 8] = dat(k);
    rst = 1'b1; mode = 1'b0; sel = '0;
    bus.in_valid = '0; bus.out_ready = 1'b0;
    mode24 = 1'b0; sel24 = '0; bus24.in_valid = '0; bus24.out_ready = 1'b0;

    // Reset state; reset also blocks in_ready even with valid requests.
    step(); step();
    bus.in_valid = '1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);

    // Manual select of channel 5.
    rst = 1'b0; sel = 5'd5; bus.in_valid = 32'h0000_0020; bus.out_ready = 1'b1;
    #1 chk("man_in_ready", 64'(bus.in_ready), 64'h20);
    exp_q.push_back(5);
    step();
    bus.in_valid = '0;
    #1 chk("man_out_valid", 64'(bus.out_valid), 64'd1);
    step();
    #1;
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_keep_data", 64'(bus.out_data), 64'hA5);
    chk("drain_keep_ch", 64'(bus.out_ch), 64'd5);

    // Scan over all channels from a fresh reset: 0..31, 0, 1.
    rst = 1'b1;
    step();
    rst = 1'b0; mode = 1'b1; bus.in_valid = '1; bus.out_ready = 1'b1;
    for (int i = 0; i < 34; i++) begin
      #1 chk("scan_all_ready", 64'(bus.in_ready), 64'(32'd1 << (i % 32)));
      exp_q.push_back(i % 32);
      step();
    end
    bus.in_valid = '0;
    step();

    // ptr is 2; a grant on 3 moves it to 4, then 30, 3 (wrap), 30.
    bus.in_valid = 32'h0000_0008;
    #1 chk("scan_to4_ready", 64'(bus.in_ready), 64'h8);
    exp_q.push_back(3);
    step();
    bus.in_valid = 32'h4000_0008;
    for (int j = 0; j < 3; j++) begin
      #1 chk("scan_wrap_ready", 64'(bus.in_ready), 64'(32'd1 << e3[j]));
      exp_q.push_back(e3[j]);
      step();
    end
    bus.in_valid = '0;
    step();

    // ptr is 31: searching from 31 picks 31 over 0.
    bus.in_valid = 32'h8000_0001;
    #1 chk("scan_ptr31_ready", 64'(bus.in_ready), 64'h8000_0000);
    exp_q.push_back(31);
    step();
    bus.in_valid = '0; mode = 1'b0;
    step();

    // Stall: word from ch7 held five cycles, then ch9 loads on release.
    sel = 5'd7; bus.in_valid = 32'h0000_0080; bus.out_ready = 1'b0;
    #1 chk("stall_load_ready", 64'(bus.in_ready), 64'h80);
    exp_q.push_back(7);
    step();
    sel = 5'd9; bus.in_valid = 32'h0000_0200;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_out_data", 64'(bus.out_data), 64'(dat(7)));
      chk("stall_out_ch", 64'(bus.out_ch), 64'd7);
      step();
    end
    bus.out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(bus.in_ready), 64'h200);
    exp_q.push_back(9);
    step();
    bus.in_valid = '0;
    step();

    // Reset during a stall discards the word and returns ptr to 0.
    mode = 1'b1; bus.in_valid = 32'h0000_0004; bus.out_ready = 1'b0;
    #1 chk("pre_rst_ready", 64'(bus.in_ready), 64'h4);
    step();
    #1;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("pre_rst_stall", 64'(bus.in_ready), 64'd0);
    rst = 1'b1; bus.out_ready = 1'b1;
    #1 chk("rst_block_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = '1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_data", 64'(bus.out_data), 64'd0);
    chk("midrst_out_ch", 64'(bus.out_ch), 64'd0);
    chk("midrst_ptr0_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(0);
    step();
    bus.in_valid = '0; bus.out_ready = 1'b1;
    step();

    // 24-channel instance: out-of-range manual select pulses sel_err.
    mode24 = 1'b0; sel24 = 5'd27; bus24.in_valid = '1; bus24.out_ready = 1'b1;
    #1 chk("n24_in_ready", 64'(bus24.in_ready), 64'd0);
    step();
    #1;
    chk("n24_sel_err1", 64'(sel_err24), 64'd1);
    chk("n24_out_valid1", 64'(bus24.out_valid), 64'd0);
    chk("n24_in_ready1", 64'(bus24.in_ready), 64'd0);
    step();
    #1;
    chk("n24_sel_err2", 64'(sel_err24), 64'd1);
    chk("n24_out_valid2", 64'(bus24.out_valid), 64'd0);
    mode24 = 1'b1;
    step();
    #1;
    chk("n24_scan_sel_err", 64'(sel_err24), 64'd0);
    chk("n24_scan_valid", 64'(bus24.out_valid), 64'd1);
    chk("n24_scan_ch", 64'(bus24.out_ch), 64'd0);
    bus24.in_valid = '0;

    // Let the scoreboard drain, bounded.
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) step();
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
